// File: rtl/axil_master_port.sv
// Single-outstanding AXI4-Lite initiator: local command in, one completion out.
// Optional watchdog with ERR state when AXIM_TIMEOUT_EN is defined.
module axil_master_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int RESP_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    m0_axi_aclk,
  input  logic                    m0_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8:0]   cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [RESP_WIDTH-1:0]   rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
  output logic                    m0_axi_awvalid,
  input  logic                    m0_axi_awready,
  output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
  output logic [DATA_WIDTH/8:0]   m0_axi_wstrb,
  output logic                    m0_axi_wvalid,
  input  logic                    m0_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m0_axi_bresp,
  input  logic                    m0_axi_bvalid,
  output logic                    m0_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
  output logic                    m0_axi_arvalid,
  input  logic                    m0_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m0_axi_rresp,
  input  logic                    m0_axi_rvalid,
  output logic                    m0_axi_rready
);

  localparam int NB = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic                  aw_done;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [RESP_WIDTH-1:0] resp_q;

  // Decodes are gated by reset so every output reads 0 while it is held.
  logic run;
  logic in_idle;
  logic in_wr;
  logic in_wr_resp;
  logic in_rd_addr;
  logic in_rd_data;
  logic in_rsp;
  logic err_rsp;

  assign run        = ~m0_axi_areset;
  assign in_idle    = run & (state == S_IDLE);
  assign in_wr      = run & (state == S_WR);
  assign in_wr_resp = run & (state == S_WR_RESP);
  assign in_rd_addr = run & (state == S_RD_ADDR);
  assign in_rd_data = run & (state == S_RD_DATA);
  assign in_rsp     = run & (state == S_RSP);

  logic aw_hs;
  logic w_hs;

  assign aw_hs = m0_axi_awvalid & m0_axi_awready;
  assign w_hs  = m0_axi_wvalid & m0_axi_wready;

`ifdef AXIM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt;
  logic          timed;
  logic          in_err;
  logic          err_ack;

  assign timed   = (state == S_WR) | (state == S_WR_RESP) |
                   (state == S_RD_ADDR) | (state == S_RD_DATA);
  assign in_err  = run & (state == S_ERR);
  assign err_rsp = in_err & ~err_ack;
`else
  assign err_rsp = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (cmd_valid) state_nx = cmd_write ? S_WR : S_RD_ADDR;
      S_WR:
        if ((aw_done | aw_hs) & (w_done | w_hs)) state_nx = S_WR_RESP;
      S_WR_RESP:
        if (m0_axi_bvalid) state_nx = S_RSP;
      S_RD_ADDR:
        if (m0_axi_arready) state_nx = S_RD_DATA;
      S_RD_DATA:
        if (m0_axi_rvalid) state_nx = S_RSP;
      S_RSP:
        if (rsp_ready) state_nx = S_IDLE;
      S_ERR:
        state_nx = S_ERR;
      default:
        state_nx = S_IDLE;
    endcase
`ifdef AXIM_TIMEOUT_EN
    if (timed && (state_nx == state) &&
        (cnt == CW'(TIMEOUT_CYCLES - 1)))
      state_nx = S_ERR;
`endif
  end

  always_ff @(posedge m0_axi_aclk) begin
    if (m0_axi_areset) begin
      state   <= S_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (cmd_valid) begin
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
          strb_q  <= cmd_wstrb[NB-1:0];
        end
      end
      if (state == S_WR) begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end
      if ((state == S_WR_RESP) && m0_axi_bvalid) begin
        resp_q  <= m0_axi_bresp;
        rdata_q <= '0;
      end
      if ((state == S_RD_DATA) && m0_axi_rvalid) begin
        resp_q  <= m0_axi_rresp;
        rdata_q <= m0_axi_rdata;
      end
    end
  end

`ifdef AXIM_TIMEOUT_EN
  always_ff @(posedge m0_axi_aclk) begin
    if (m0_axi_areset) begin
      cnt     <= '0;
      err_ack <= 1'b0;
    end else begin
      if (state_nx != state) cnt <= '0;
      else if (timed)        cnt <= cnt + 1'b1;
      if ((state == S_ERR) && rsp_ready) err_ack <= 1'b1;
    end
  end
`endif

  assign cmd_ready      = in_idle;
  assign m0_axi_awvalid = in_wr & ~aw_done;
  assign m0_axi_wvalid  = in_wr & ~w_done;
  assign m0_axi_awaddr  = in_wr ? addr_q : '0;
  assign m0_axi_wdata   = in_wr ? wdata_q : '0;
  assign m0_axi_wstrb   = in_wr ? {1'b0, strb_q} : '0;
  assign m0_axi_bready  = in_wr_resp;
  assign m0_axi_arvalid = in_rd_addr;
  assign m0_axi_araddr  = in_rd_addr ? addr_q : '0;
  assign m0_axi_rready  = in_rd_data;

  assign rsp_valid = in_rsp | err_rsp;
  assign rsp_rdata = in_rsp ? rdata_q : '0;
  assign rsp_resp  = in_rsp  ? resp_q :
                     err_rsp ? '1 : '0;

  logic unused_ok;
  assign unused_ok = ^{cmd_wstrb[NB], 1'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_axil_master_port.sv
// Randomized bench for axil_master_port: memory-backed slave plus reference memory.
// Build with AXIM_TIMEOUT_EN defined to also exercise the watchdog.
module tb_axil_master_port;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int NB = DW / 8;
  localparam int SW = NB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset = 1'b1;
  logic          cmd_valid = 0;
  logic          cmd_ready;
  logic          cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 0;
  logic [DW-1:0] rsp_rdata;
  logic [RW-1:0] rsp_resp;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready = 0;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready = 0;
  logic [RW-1:0] bresp = '0;
  logic          bvalid = 0;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready = 0;
  logic [DW-1:0] rdata = '0;
  logic [RW-1:0] rresp = '0;
  logic          rvalid = 0;
  logic          rready;

  axil_master_port #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .RESP_WIDTH(RW), .TIMEOUT_CYCLES(16)
  ) dut (
    .m0_axi_aclk(clk), .m0_axi_areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m0_axi_awaddr(awaddr), .m0_axi_awvalid(awvalid),
    .m0_axi_awready(awready),
    .m0_axi_wdata(wdata), .m0_axi_wstrb(wstrb),
    .m0_axi_wvalid(wvalid), .m0_axi_wready(wready),
    .m0_axi_bresp(bresp), .m0_axi_bvalid(bvalid),
    .m0_axi_bready(bready),
    .m0_axi_araddr(araddr), .m0_axi_arvalid(arvalid),
    .m0_axi_arready(arready),
    .m0_axi_rdata(rdata), .m0_axi_rresp(rresp),
    .m0_axi_rvalid(rvalid), .m0_axi_rready(rready)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] slave_mem [64];
  logic [DW-1:0] ref_mem [64];

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
              awaddr, awvalid, wdata, wstrb, wvalid, bready,
              araddr, arvalid, rready}, '0);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] nw,
                                          input logic [NB-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++)
      if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // One complete command; slave delays count cycles a valid waits for ready.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data,
                         input logic [NB-1:0] strb,
                         input int a_d, input int w_d, input int x_d,
                         input int hold, input logic [RW-1:0] resp);
    int ad = a_d, wd = w_d, xd = x_d;
    int lat = 0, ac = 0, wc = 0;
    bit a_got = 0, w_got = 0, x_got = 0, x_prev = 0, done = 0;
    bit both, busy_bad = 0, hold_bad = 0;
    logic [AW-1:0] cap_a = '0;
    logic [DW-1:0] cap_d = '0;
    logic [SW-1:0] cap_s = '0;
    logic [DW-1:0] exp_rd;
    int exp_lat;
    exp_rd  = wr ? '0 : ref_mem[addr[7:2]];
    exp_lat = wr ? 3 + ((a_d > w_d) ? a_d : w_d) + x_d
                 : 3 + a_d + x_d;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = {1'b1, strb};
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      if (x_prev) begin bvalid = 0; rvalid = 0; x_prev = 0; end
      if (rsp_valid) begin
        lat = c; done = 1;
      end else begin
        if (cmd_ready) busy_bad = 1;
        both = wr ? (a_got && w_got) : a_got;
        if (wr) begin
          if (awvalid) ac++;
          if (wvalid) wc++;
          awready = awvalid && ad == 0;
          if (awvalid && ad > 0) ad--;
          if (awvalid && awready) begin a_got = 1; cap_a = awaddr; end
          wready = wvalid && wd == 0;
          if (wvalid && wd > 0) wd--;
          if (wvalid && wready) begin w_got = 1; cap_d = wdata; cap_s = wstrb; end
        end else begin
          if (arvalid) ac++;
          arready = arvalid && ad == 0;
          if (arvalid && ad > 0) ad--;
          if (arvalid && arready) begin a_got = 1; cap_a = araddr; end
        end
        if (both && !x_got) begin
          if (xd == 0) begin
            if (wr) begin bvalid = 1; bresp = resp; end
            else begin
              rvalid = 1; rresp = resp;
              rdata = slave_mem[cap_a[7:2]];
            end
          end else xd--;
          if ((bvalid && bready) || (rvalid && rready)) begin
            x_got = 1; x_prev = 1;
            if (wr)
              slave_mem[cap_a[7:2]] = merge(slave_mem[cap_a[7:2]], cap_d, cap_s[NB-1:0]);
          end
        end
      end
    end
    awready = 0; wready = 0; arready = 0;
    chk("txn_done", done, 1'b1);
    if (!done) return;
    chk("busy_cmd_ready", busy_bad, 1'b0);
    chk("latency", lat, exp_lat);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_resp", rsp_resp, resp);
    chk(wr ? "awaddr" : "araddr", cap_a, addr);
    chk(wr ? "aw_cycles" : "ar_cycles", ac, a_d + 1);
    if (wr) begin
      chk("wdata", cap_d, data);
      chk("wstrb", cap_s, {1'b0, strb});
      chk("w_cycles", wc, w_d + 1);
      ref_mem[addr[7:2]] = merge(ref_mem[addr[7:2]], data, strb);
    end
    rsp_ready = (hold == 0);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1 || rsp_rdata !== exp_rd ||
          rsp_resp !== resp || cmd_ready !== 0) hold_bad = 1;
      if (i == hold) rsp_ready = 1;
    end
    if (hold > 0) chk("rsp_hold", hold_bad, 1'b0);
    @(negedge clk);
    rsp_ready = 0;
    chk("after_rsp", {cmd_ready, rsp_valid}, 2'b10);
  endtask

  // Accept a write, let aw/w complete, stop once bready is seen.
  task automatic write_to_wresp(output bit ok);
    ok = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h20;
    cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 5'h0F;
    awready = 1; wready = 1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      if (bready) ok = 1;
    end
    awready = 0; wready = 0;
    chk("reach_wr_resp", ok, 1'b1);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 64; i++) begin
      slave_mem[i] = '0; ref_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_outs_zero("reset_outs");
    areset = 0;
    @(negedge clk);
    chk("cmd_ready_post_reset", cmd_ready, 1'b1);

    run_txn(1, 8'h04, 32'h0000_0005, 4'hF, 0, 0, 0, 0, 3'd0);
    run_txn(1, 8'h08, 32'h1234_5678, 4'hF, 3, 0, 0, 0, 3'd0);
    run_txn(1, 8'h0C, 32'h0000_000F, 4'hF, 0, 0, 0, 0, 3'd0);
    run_txn(0, 8'h0C, '0, '0, 0, 0, 0, 0, 3'd0);
    run_txn(0, 8'h08, '0, '0, 0, 0, 0, 5, 3'd2);
    run_txn(1, 8'h10, 32'hAABB_CCDD, 4'h5, 0, 2, 1, 1, 3'd1);
    run_txn(0, 8'h10, '0, '0, 1, 0, 2, 0, 3'd7);

    write_to_wresp(ok);
    areset = 1;
    @(negedge clk);
    chk_outs_zero("mid_reset_outs");
    areset = 0;
    @(negedge clk);
    chk("cmd_ready_after_mid_reset", cmd_ready, 1'b1);
    run_txn(0, 8'h20, '0, '0, 0, 0, 0, 0, 3'd0);

    for (int n = 0; n < 40; n++)
      run_txn($urandom_range(0, 1), AW'($urandom), $urandom,
              NB'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              RW'($urandom));

`ifdef AXIM_TIMEOUT_EN
    begin
      int c;
      write_to_wresp(ok);
      c = 0;
      while (!rsp_valid && c < 40) begin
        @(negedge clk);
        c++;
      end
      chk("timeout_latency", c, 16);
      chk("timeout_resp", {rsp_resp, rsp_rdata, bready}, {3'b111, 33'd0});
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      chk("err_acked", {rsp_valid, cmd_ready}, 2'b00);
      repeat (5) @(negedge clk);
      chk("err_sticky", cmd_ready, 1'b0);
      areset = 1;
      @(negedge clk);
      areset = 0;
      @(negedge clk);
      chk("err_reset", cmd_ready, 1'b1);
      run_txn(0, 8'h04, '0, '0, 0, 0, 0, 0, 3'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule
